// File: rtl/pic_multi.sv
`default_nettype none
// ============================================================================
// Module   : pic_multi
// Purpose  : 8259-style programmable interrupt controller, 1..8 edge-triggered
//            IRQ lines, fixed priority (IRQ0 highest), mask / in-service
//            registers, EOI commands and the two-pulse INTA vector sequence.
// Options  : PIC_AUTO_EOI_EN - clear the in-service bit automatically when
//            the second INTA pulse ends.
// Revision : 1.0 - initial release
// ============================================================================
module pic_multi #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] BASE_PORT   = 16'h0020,
  parameter logic [7:0]  VECTOR_BASE = 8'h08
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [19:0]        iAddr,
  input  logic               iRd,
  input  logic               iWr,
  input  logic [7:0]         iData,
  input  logic               iIntAck,
  input  logic [NUM_IRQ-1:0] iIrq,
  output logic               oInt,
  output logic               oSel,
  output logic [7:0]         oData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK1 = 2'd1,
    S_ACK2 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_irr;
  logic [NUM_IRQ-1:0] r_isr;
  logic [NUM_IRQ-1:0] r_imr;
  logic               r_rsel;     // 0: read IRR at BASE_PORT, 1: read ISR
  logic               r_ack_q;
  logic               r_int;
  logic [2:0]         r_vec_idx;

  logic [7:0] w_irr8, w_isr8, w_imr8, w_pend8;
  logic [7:0] w_set8, w_clr8;
  logic [3:0] w_win, w_isr_low;
  logic       w_ack_rise, w_ack_fall, w_accept, w_spur;
  logic       w_sel_cmd, w_sel_data, w_wr_cmd, w_wr_data;
  logic       w_icw1, w_eoi_ns, w_eoi_sp;
  logic       w_vec_sel, w_rd_sel;
  logic       w_unused;

  // Index of the lowest set bit, 8 when the vector is empty.
  function automatic logic [3:0] lowest8(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign w_unused = ^iAddr[19:16];

  // Zero-extend the per-line registers to the 8-bit register view.
  always_comb begin
    w_irr8 = 8'd0;
    w_isr8 = 8'd0;
    w_imr8 = 8'd0;
    w_irr8[NUM_IRQ-1:0] = r_irr;
    w_isr8[NUM_IRQ-1:0] = r_isr;
    w_imr8[NUM_IRQ-1:0] = r_imr;
  end

  assign w_pend8    = w_irr8 & ~w_imr8;
  assign w_win      = lowest8(w_pend8);
  assign w_isr_low  = lowest8(w_isr8);
  assign w_spur     = (w_pend8 == 8'd0);

  assign w_ack_rise = iIntAck & ~r_ack_q;
  assign w_ack_fall = ~iIntAck & r_ack_q;
  assign w_accept   = (r_state == S_IDLE) & w_ack_rise;

  assign w_sel_cmd  = (iAddr[15:0] == BASE_PORT);
  assign w_sel_data = (iAddr[15:0] == BASE_PORT + 16'd1);
  assign w_wr_cmd   = iWr & w_sel_cmd;
  assign w_wr_data  = iWr & w_sel_data;
  assign w_icw1     = w_wr_cmd & iData[4];
  assign w_eoi_ns   = w_wr_cmd & (iData == 8'h20);
  assign w_eoi_sp   = w_wr_cmd & (iData[7:3] == 5'b01100) & (int'(iData[2:0]) < NUM_IRQ);

  assign w_set8 = (w_accept & ~w_spur) ? (8'd1 << w_win[2:0]) : 8'd0;

`ifdef PIC_AUTO_EOI_EN
  logic r_spur;

  // Remember whether the current INTA sequence was spurious so auto-EOI skips it.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_spur <= 1'b0;
    end else if (w_accept) begin
      r_spur <= w_spur;
    end
  end
`endif

  // In-service clear mask from EOI commands (and auto-EOI when enabled).
  always_comb begin
    w_clr8 = 8'd0;
    if (w_eoi_ns && (w_isr8 != 8'd0)) w_clr8 = w_clr8 | (8'd1 << w_isr_low[2:0]);
    if (w_eoi_sp)                     w_clr8 = w_clr8 | (8'd1 << iData[2:0]);
`ifdef PIC_AUTO_EOI_EN
    if ((r_state == S_ACK2) && w_ack_fall && !r_spur)
      w_clr8 = w_clr8 | (8'd1 << r_vec_idx);
`endif
  end

  // INTA phase register.
  always_ff @(posedge iClk) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // INTA phase sequencing: rise -> ACK1, fall -> ACK2, fall -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ack_rise) w_state_nxt = S_ACK1;
      S_ACK1:  if (w_ack_fall) w_state_nxt = S_ACK2;
      S_ACK2:  if (w_ack_fall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request/service/mask registers; sets are applied after clears so they win.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_irq_q   <= '0;
      r_irr     <= '0;
      r_isr     <= '0;
      r_imr     <= '1;
      r_rsel    <= 1'b0;
      r_ack_q   <= 1'b0;
      r_int     <= 1'b0;
      r_vec_idx <= 3'd0;
    end else begin
      r_irq_q <= iIrq;
      r_ack_q <= iIntAck;
      r_int   <= (w_pend8 != 8'd0) && (w_win < w_isr_low);
      if (w_accept) r_vec_idx <= w_spur ? 3'd7 : w_win[2:0];
      if (w_icw1) begin
        r_irr  <= '0;
        r_isr  <= '0;
        r_imr  <= '0;
        r_rsel <= 1'b0;
      end else begin
        r_irr <= (r_irr & ~w_set8[NUM_IRQ-1:0]) | (iIrq & ~r_irq_q);
        r_isr <= (r_isr & ~w_clr8[NUM_IRQ-1:0]) | w_set8[NUM_IRQ-1:0];
        if (w_wr_data) r_imr <= iData[NUM_IRQ-1:0];
        if (w_wr_cmd && (iData == 8'h0A)) r_rsel <= 1'b0;
        if (w_wr_cmd && (iData == 8'h0B)) r_rsel <= 1'b1;
      end
    end
  end

  // Read / vector bus drive; the INTA vector takes precedence over a port read.
  always_comb begin
    w_vec_sel = (r_state == S_ACK2) & iIntAck;
    w_rd_sel  = iRd & (w_sel_cmd | w_sel_data);
    oSel      = ~iRst & (w_vec_sel | w_rd_sel);
    oData     = 8'd0;
    if (oSel) begin
      if (w_vec_sel)      oData = VECTOR_BASE + {5'd0, r_vec_idx};
      else if (w_sel_cmd) oData = r_rsel ? w_isr8 : w_irr8;
      else                oData = w_imr8;
    end
  end

  assign oInt = r_int;

endmodule
`default_nettype wire
